tlc_farm_road_monitor: RTL and testbench
========================================

// Module: tlc_farm_road_monitor
// PURPOSE
//  Roadside counterpart of the highway/farm traffic-light controller.
//  - Debounces the raw farm-road vehicle detector into the controller's FM request and synchronizes the TEST request.
//  - Watches the six lamp outputs (GRN1/YLW1/RED1 highway, GRN2/YLW2/RED2 farm), tracks the signal phase and flags illegal lamp sequences.
//  - Sits beside the controller on the same clock and feeds its FM/TEST inputs.
// PARAMETERS
//  DEB_CYCLES  4  consecutive synchronized CAR_DET-high cycles before FM asserts (1..15)
//  MIN_YLW     3  minimum cycles a yellow phase must persist (1..255)
// PORTS
//  CK        in   1  clock, rising edge
//  CLR       in   1  reset, asynchronous, active-high
//  CAR_DET   in   1  raw farm-road detector, asynchronous to CK
//  TEST_REQ  in   1  raw test-mode request, asynchronous to CK
//  GRN1 YLW1 RED1  in  1 each  highway lamps from controller, synchronous to CK
//  GRN2 YLW2 RED2  in  1 each  farm lamps from controller, synchronous to CK
//  ERR_CLR   in   1  synchronous clear of ERR/ERR_CODE
//  FM        out  1  farm-road service request to controller
//  TEST      out  1  synchronized TEST_REQ
//  PHASE     out  3  0=UNK 1=HG 2=HY 3=FG 4=FY
//  DWELL     out  8  cycles spent in current PHASE, saturating at 255
//  ERR       out  1  sticky violation flag
//  ERR_CODE  out  3  code of first violation since last clear
// BEHAVIOUR
//  Reset (CLR=1): all outputs and internal state 0, PHASE=UNK, sync flops 0.
//  Sync: CAR_DET and TEST_REQ each pass 2 flops. TEST = 2nd TEST_REQ flop (2-cycle latency).
//  Debounce counter DC (4b):
//  - sync CAR_DET=0 -> DC=0.
//  - Else if FM=0, DC++; FM sets on the edge where DC reaches DEB_CYCLES.
//  - DC is held while FM=1.
//  - FM clears on the edge after GRN2=1 is sampled; DC=0 on that edge.
//  - GRN2=1 while FM=0 is not an error; no request is latched.
//  Lamp decode, combinational on each cycle's lamp inputs:
//    HG = GRN1&RED2
//    HY = YLW1&RED2
//    FG = RED1&GRN2
//    FY = RED1&YLW2
//    each road exactly one lamp on
//  PHASE register updates on the edge that samples the new pattern (1-cycle latency).
//  Legal transitions: HG->HY->FG->FY->HG, plus staying in the same phase.
//  From UNK: first legal pattern is accepted without a transition check.
//  Violations (checked each cycle, PHASE != UNK unless noted):
//  - code 1: a road has 0 or >1 lamps on (checked in UNK too).
//  - code 2: both roads non-red (conflict), including GRN1&GRN2 (checked in UNK too).
//  - code 3: legal pattern, but not the successor of PHASE (skip or backward step).
//  - code 4: leaving HY or FY with DWELL+1 < MIN_YLW.
//  - Precedence when several hit in one cycle: 2 > 1 > 3 > 4.
//  On a violation:
//  - ERR=1; ERR_CODE is loaded only if ERR was 0 (first error wins).
//  - PHASE -> UNK and DWELL -> 0 for codes 1, 2.
//  - For codes 3, 4, PHASE takes the new legal value.
//  DWELL:
//  - 0 on entry to a new PHASE.
//  - +1 each cycle the phase holds; saturates at 255, no wrap.
//  ERR_CLR=1: ERR, ERR_CODE -> 0 on that edge.
//  - A violation in the same cycle wins: ERR=1 and the new code loads.
//  - PHASE, DWELL and FM are unaffected.
//  CLR mid-operation: asynchronous return to reset values; FM drops immediately.
// TESTING
//  1 CAR_DET high 10 cycles, DEB_CYCLES=4, lamps HG:
//    FM=1 on the 6th edge (2 sync + 4 count).
//    Drive FG: FM=0 one edge later.
//  2 CAR_DET pulses 3 high/1 low, repeated:
//    FM never asserts; DC returns to 0 each low cycle.
//  3 Lamps HG(5) -> HY(3) -> FG(6) -> FY(3) -> HG:
//    PHASE 1,2,3,4,1 with 1-cycle lag; DWELL peaks 4,2,5,2; ERR=0.
//  4 HG(5) -> FG directly:
//    ERR=1, ERR_CODE=3, PHASE=3.
//    Then GRN1&GRN2: ERR_CODE stays 3, PHASE=UNK.
//  5 HG -> HY for 1 cycle -> FG, MIN_YLW=3:
//    ERR_CODE=4.
//    ERR_CLR with no violation: ERR=0, ERR_CODE=0.
//  6 CLR asserted mid-FG with FM=1, ERR=1:
//    all outputs 0 asynchronously; PHASE=UNK after release.

Source files
------------

// File: rtl/tlc_farm_road_monitor_if.sv
// ---------------------------------------------------------------------------
// tlc_farm_road_monitor_if
// Signal bundle between the highway/farm traffic-light controller side and
// the roadside monitor.
//   master : drives detector/test requests, the six lamps and err_clr;
//            receives fm, test, phase, dwell, err, err_code.
//   slave  : the monitor itself (mirror image of master).
// Lamp bits: grn1/ylw1/red1 = highway, grn2/ylw2/red2 = farm road.
// phase encoding: 0=UNK 1=HG 2=HY 3=FG 4=FY.
// ---------------------------------------------------------------------------
interface tlc_farm_road_monitor_if;
  logic       car_det;
  logic       test_req;
  logic       grn1;
  logic       ylw1;
  logic       red1;
  logic       grn2;
  logic       ylw2;
  logic       red2;
  logic       err_clr;
  logic       fm;
  logic       test;
  logic [2:0] phase;
  logic [7:0] dwell;
  logic       err;
  logic [2:0] err_code;

  modport master (
    output car_det, test_req, grn1, ylw1, red1, grn2, ylw2, red2, err_clr,
    input  fm, test, phase, dwell, err, err_code
  );

  modport slave (
    input  car_det, test_req, grn1, ylw1, red1, grn2, ylw2, red2, err_clr,
    output fm, test, phase, dwell, err, err_code
  );
endinterface

// File: rtl/tlc_farm_road_monitor.sv
// ---------------------------------------------------------------------------
// tlc_farm_road_monitor
// Roadside companion of the highway/farm traffic-light controller.
//  - Synchronizes the raw farm-road detector and debounces it into the
//    controller's farm-road service request (fm); fm holds until the farm
//    green lamp is seen.
//  - Synchronizes the raw test-mode request (test, 2-cycle latency).
//  - Decodes the six lamps into a signal phase, tracks how long the phase has
//    held (dwell, saturating) and flags illegal lamp patterns / sequences with
//    a sticky err plus the code of the first violation.
// Ports:
//   ck   : clock, rising edge
//   clr  : asynchronous active-high reset
//   bus  : tlc_farm_road_monitor_if.slave (inputs from the road/controller,
//          outputs fm, test, phase, dwell, err, err_code)
// Parameters:
//   DEB_CYCLES : synchronized detector-high cycles before fm asserts (1..15)
//   MIN_YLW    : minimum cycles a yellow phase must persist (1..255)
// Violation codes: 1 lamp count, 2 conflict, 3 sequence, 4 short yellow.
// Precedence within one cycle: 2 > 1 > 3 > 4.
// ---------------------------------------------------------------------------
module tlc_farm_road_monitor #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned MIN_YLW    = 3
) (
  input logic                   ck,
  input logic                   clr,
  tlc_farm_road_monitor_if.slave bus
);

  typedef enum logic [2:0] {
    PH_UNK = 3'd0,
    PH_HG  = 3'd1,
    PH_HY  = 3'd2,
    PH_FG  = 3'd3,
    PH_FY  = 3'd4
  } phase_e;

  typedef enum logic [2:0] {
    E_NONE     = 3'd0,
    E_LAMP     = 3'd1,
    E_CONFLICT = 3'd2,
    E_SEQ      = 3'd3,
    E_YLW      = 3'd4
  } err_e;

  localparam logic [3:0] DEB_W     = 4'(DEB_CYCLES);
  localparam logic [8:0] MIN_YLW_W = 9'(MIN_YLW);

  logic [1:0] car_sync;
  logic [1:0] test_sync;
  logic [3:0] dc;
  logic       fm_q;
  phase_e     phase_q;
  logic [7:0] dwell_q;
  logic       err_q;
  err_e       err_code_q;

  // Combinational lamp decode for the current cycle.
  logic   road1_ok;
  logic   road2_ok;
  logic   conflict;
  phase_e pat;
  phase_e succ;
  err_e   viol;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    road1_ok = 1'b0;
    road2_ok = 1'b0;
    conflict = 1'b0;
    pat      = PH_UNK;
    succ     = PH_UNK;
    viol     = E_NONE;

    // Exactly one lamp: odd count, but not all three.
    road1_ok = (bus.grn1 ^ bus.ylw1 ^ bus.red1) & ~(bus.grn1 & bus.ylw1 & bus.red1);
    road2_ok = (bus.grn2 ^ bus.ylw2 ^ bus.red2) & ~(bus.grn2 & bus.ylw2 & bus.red2);
    // Both roads showing a go/caution lamp, regardless of any extra red.
    conflict = (bus.grn1 | bus.ylw1) & (bus.grn2 | bus.ylw2);

    if      (bus.grn1 && bus.red2) pat = PH_HG;
    else if (bus.ylw1 && bus.red2) pat = PH_HY;
    else if (bus.red1 && bus.grn2) pat = PH_FG;
    else if (bus.red1 && bus.ylw2) pat = PH_FY;

    case (phase_q)
      PH_HG:   succ = PH_HY;
      PH_HY:   succ = PH_FG;
      PH_FG:   succ = PH_FY;
      PH_FY:   succ = PH_HG;
      default: succ = PH_UNK;
    endcase

    if (conflict) begin
      viol = E_CONFLICT;
    end else if (!(road1_ok && road2_ok)) begin
      viol = E_LAMP;
    end else if (phase_q != PH_UNK && pat != PH_UNK && pat != phase_q) begin
      if (pat != succ) begin
        viol = E_SEQ;
      end else if ((phase_q == PH_HY || phase_q == PH_FY) &&
                   (({1'b0, dwell_q} + 9'd1) < MIN_YLW_W)) begin
        viol = E_YLW;
      end
    end
  end

  // Synchronizers and detector debounce.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values and the two-stage synchronizer really is two stages.
  always_ff @(posedge ck or posedge clr) begin
    if (clr) begin
      car_sync  <= 2'b00;
      test_sync <= 2'b00;
      dc        <= 4'd0;
      fm_q      <= 1'b0;
    end else begin
      car_sync  <= {car_sync[0], bus.car_det};
      test_sync <= {test_sync[0], bus.test_req};
      if (fm_q && bus.grn2) begin
        // Farm road is being served: retire the request.
        fm_q <= 1'b0;
        dc   <= 4'd0;
      end else if (!car_sync[1]) begin
        dc <= 4'd0;
      end else if (!fm_q) begin
        dc <= dc + 4'd1;
        if (dc + 4'd1 == DEB_W) fm_q <= 1'b1;
      end
    end
  end

  // Phase tracker, dwell counter and sticky error.
  // NOTE: every flop here is control state and is cleared by the async reset;
  // there is no storage array that could be left unreset.
  always_ff @(posedge ck or posedge clr) begin
    if (clr) begin
      phase_q    <= PH_UNK;
      dwell_q    <= 8'd0;
      err_q      <= 1'b0;
      err_code_q <= E_NONE;
    end else begin
      if (viol == E_LAMP || viol == E_CONFLICT) begin
        phase_q <= PH_UNK;
        dwell_q <= 8'd0;
      end else if (pat == PH_UNK || pat == phase_q) begin
        // Same phase, or an all-red clearance pattern: the phase holds.
        if (dwell_q != 8'hff) dwell_q <= dwell_q + 8'd1;
      end else begin
        // New legal pattern (accepted from UNK, or legal/illegal step).
        phase_q <= pat;
        dwell_q <= 8'd0;
      end

      if (viol != E_NONE) begin
        err_q <= 1'b1;
        // First error wins, unless this same edge is clearing the old one.
        if (!err_q || bus.err_clr) err_code_q <= viol;
      end else if (bus.err_clr) begin
        err_q      <= 1'b0;
        err_code_q <= E_NONE;
      end
    end
  end

  assign bus.fm       = fm_q;
  assign bus.test     = test_sync[1];
  assign bus.phase    = phase_q;
  assign bus.dwell    = dwell_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_tlc_farm_road_monitor.sv
// ---------------------------------------------------------------------------
// tb_tlc_farm_road_monitor
// Directed scenarios followed by randomized lamp/detector traffic. The
// stimulus process computes the expected outputs for every clock edge from a
// behavioural model and queues them; a monitor process compares one queued
// entry against the DUT shortly after each rising edge.
// ---------------------------------------------------------------------------
module tb_tlc_farm_road_monitor;

  localparam int DEB  = 4;
  localparam int MINY = 3;

  // Lamp vectors {grn1, ylw1, red1, grn2, ylw2, red2}.
  localparam logic [5:0] L_HG   = 6'b100001;
  localparam logic [5:0] L_HY   = 6'b010001;
  localparam logic [5:0] L_FG   = 6'b001100;
  localparam logic [5:0] L_FY   = 6'b001010;
  localparam logic [5:0] L_CONF = 6'b100100;
  localparam logic [5:0] L_ALLR = 6'b001001;

  logic ck = 1'b0;
  logic clr;

  tlc_farm_road_monitor_if bus ();

  tlc_farm_road_monitor #(
    .DEB_CYCLES (DEB),
    .MIN_YLW    (MINY)
  ) dut (
    .ck  (ck),
    .clr (clr),
    .bus (bus)
  );

  always #5 ck = ~ck;

  typedef struct {
    int fm;
    int test;
    int phase;
    int dwell;
    int err;
    int code;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [5:0] lamp_tbl [4];

  // Behavioural model state.
  int m_raw_car[2];   // raw detector samples from the last two edges (newest first)
  int m_raw_test;     // raw test request from the previous edge
  int m_test;
  int m_run;          // consecutive synchronized-high detector cycles counted
  int m_fm;
  int m_phase;
  int m_dwell;
  int m_err;
  int m_code;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pat_of(input logic [5:0] l);
    for (int i = 0; i < 4; i++)
      if (lamp_tbl[i] == l) return i + 1;
    return 0;
  endfunction

  function automatic void model_reset();
    m_raw_car[0] = 0;
    m_raw_car[1] = 0;
    m_raw_test   = 0;
    m_test       = 0;
    m_run        = 0;
    m_fm         = 0;
    m_phase      = 0;
    m_dwell      = 0;
    m_err        = 0;
    m_code       = 0;
  endfunction

  // Outputs expected right after the next rising edge, given this cycle's inputs.
  function automatic void model_step(input int c_clr, input int car, input int tst,
                                     input logic [5:0] l, input int eclr);
    int n1, n2, viol, p, car_seen;
    if (c_clr != 0) begin
      model_reset();
      return;
    end
    // TEST shows the request sampled one edge earlier (two flops of latency).
    m_test     = m_raw_test;
    m_raw_test = tst;
    // The debouncer sees the detector as it was two edges ago.
    car_seen     = m_raw_car[1];
    m_raw_car[1] = m_raw_car[0];
    m_raw_car[0] = car;
    if (m_fm != 0 && l[2]) begin
      m_fm  = 0;
      m_run = 0;
    end else if (car_seen == 0) begin
      m_run = 0;
    end else if (m_fm == 0) begin
      m_run++;
      if (m_run == DEB) m_fm = 1;
    end
    // Lamp rules.
    n1   = $countones(l[5:3]);
    n2   = $countones(l[2:0]);
    p    = pat_of(l);
    viol = 0;
    if ((l[5] || l[4]) && (l[2] || l[1])) viol = 2;
    else if (n1 != 1 || n2 != 1)          viol = 1;
    if (viol != 0) begin
      m_phase = 0;
      m_dwell = 0;
    end else if (p == 0 || p == m_phase) begin
      m_dwell = (m_dwell == 255) ? 255 : m_dwell + 1;
    end else begin
      if (m_phase != 0) begin
        if (p != (m_phase % 4) + 1) viol = 3;
        else if ((m_phase == 2 || m_phase == 4) && m_dwell + 1 < MINY) viol = 4;
      end
      m_phase = p;
      m_dwell = 0;
    end
    if (viol != 0) begin
      if (m_err == 0 || eclr != 0) m_code = viol;
      m_err = 1;
    end else if (eclr != 0) begin
      m_err  = 0;
      m_code = 0;
    end
  endfunction

  task automatic drive(input int c_clr, input int car, input int tst,
                       input logic [5:0] l, input int eclr);
    clr          = (c_clr != 0);
    bus.car_det  = (car != 0);
    bus.test_req = (tst != 0);
    {bus.grn1, bus.ylw1, bus.red1, bus.grn2, bus.ylw2, bus.red2} = l;
    bus.err_clr  = (eclr != 0);
  endtask

  // One clock cycle: drive, queue the expectation, wait for the next falling edge.
  task automatic cyc(input int car, input int tst, input logic [5:0] l,
                     input int eclr = 0, input int c_clr = 0);
    exp_t e;
    drive(c_clr, car, tst, l, eclr);
    model_step(c_clr, car, tst, l, eclr);
    e = '{m_fm, m_test, m_phase, m_dwell, m_err, m_code};
    sb_q.push_back(e);
    @(negedge ck);
  endtask

  task automatic hold(input int n, input int car, input logic [5:0] l);
    for (int i = 0; i < n; i++) cyc(car, 0, l);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fm"},       int'(bus.fm),       0);
    check({tag, "_test"},     int'(bus.test),     0);
    check({tag, "_phase"},    int'(bus.phase),    0);
    check({tag, "_dwell"},    int'(bus.dwell),    0);
    check({tag, "_err"},      int'(bus.err),      0);
    check({tag, "_err_code"}, int'(bus.err_code), 0);
  endtask

  // Monitor: one expectation per rising edge.
  initial begin
    forever begin
      @(posedge ck);
      #1;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: DUT output at %0t had no expected entry", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("fm",       int'(bus.fm),       e.fm);
        check("test",     int'(bus.test),     e.test);
        check("phase",    int'(bus.phase),    e.phase);
        check("dwell",    int'(bus.dwell),    e.dwell);
        check("err",      int'(bus.err),      e.err);
        check("err_code", int'(bus.err_code), e.code);
      end
    end
  end

  initial begin
    int cur, left, car_v, car_left, r;
    logic [5:0] l;

    lamp_tbl[0] = L_HG;
    lamp_tbl[1] = L_HY;
    lamp_tbl[2] = L_FG;
    lamp_tbl[3] = L_FY;
    model_reset();

    // Reset state.
    drive(1, 0, 0, L_HG, 0);
    #1;
    check_all_zero("reset");
    cyc(0, 0, L_HG, 0, 1);
    cyc(0, 0, L_HG, 0, 1);

    // 1: detector held high; fm after 2 sync + DEB count edges, retired by FG.
    hold(2, 0, L_HG);
    hold(5, 1, L_HG);
    check("s1_fm_before", int'(bus.fm), 0);
    cyc(1, 0, L_HG);
    check("s1_fm_set", int'(bus.fm), 1);
    hold(4, 1, L_HG);
    hold(3, 0, L_HY);
    check("s1_fm_held", int'(bus.fm), 1);
    cyc(0, 0, L_FG);
    check("s1_fm_clear", int'(bus.fm), 0);
    hold(5, 0, L_FG);
    hold(3, 0, L_FY);
    hold(2, 0, L_HG);

    // 2: 3-high/1-low detector pulses never reach the debounce threshold.
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) cyc(1, 1, L_HG);
      cyc(0, 1, L_HG);
    end
    hold(3, 0, L_HG);
    check("s2_fm_never", int'(bus.fm), 0);
    check("s2_test", int'(bus.test), 0);

    // 3: full legal cycle.
    cyc(0, 0, L_HG, 1);
    hold(5, 0, L_HG);
    hold(3, 0, L_HY);
    check("s3_hy_dwell", int'(bus.dwell), 2);
    hold(6, 0, L_FG);
    hold(3, 0, L_FY);
    hold(2, 0, L_HG);
    check("s3_err", int'(bus.err), 0);
    check("s3_phase", int'(bus.phase), 1);

    // 4: skip HG -> FG, then a green/green conflict.
    hold(5, 0, L_HG);
    cyc(0, 0, L_FG);
    check("s4_err", int'(bus.err), 1);
    check("s4_code", int'(bus.err_code), 3);
    check("s4_phase", int'(bus.phase), 3);
    cyc(0, 0, L_CONF);
    check("s4_code_kept", int'(bus.err_code), 3);
    check("s4_phase_unk", int'(bus.phase), 0);

    // 5: short yellow, then a clean error clear.
    cyc(0, 0, L_HG, 1);
    check("s5_cleared", int'(bus.err), 0);
    hold(2, 0, L_HG);
    cyc(0, 0, L_HY);
    cyc(0, 0, L_FG);
    check("s5_code", int'(bus.err_code), 4);
    check("s5_phase", int'(bus.phase), 3);
    cyc(0, 0, L_FG, 1);
    check("s5_err_clr", int'(bus.err), 0);
    check("s5_code_clr", int'(bus.err_code), 0);

    // 6: asynchronous reset with fm and err both set.
    cyc(0, 0, L_HG);
    hold(7, 1, L_HG);
    check("s6_fm_pre", int'(bus.fm), 1);
    check("s6_err_pre", int'(bus.err), 1);
    drive(1, 1, 0, L_FG, 0);
    #1;
    check_all_zero("s6_async");
    cyc(1, 0, L_FG, 0, 1);
    hold(3, 0, L_FG);

    // Randomized traffic.
    cur      = 3;
    left     = 2;
    car_v    = 0;
    car_left = 3;
    for (int n = 0; n < 3000; n++) begin
      if (left == 0) begin
        r = $urandom_range(0, 19);
        if (r < 17) cur = (cur % 4) + 1;
        else        cur = $urandom_range(1, 4);
        left = $urandom_range(1, 6);
      end
      left--;
      l = lamp_tbl[cur - 1];
      r = $urandom_range(0, 39);
      if (r == 0) begin
        l = L_CONF;
      end else if (r == 1) begin
        l = 6'($urandom_range(0, 63));
        if (l == L_ALLR) l = 6'b000000;
      end
      if (car_left == 0) begin
        car_v    = ~car_v & 1;
        car_left = $urandom_range(1, 8);
      end
      car_left--;
      cyc(car_v, int'($urandom_range(0, 1)), l,
          ($urandom_range(0, 15) == 0) ? 1 : 0,
          ($urandom_range(0, 999) == 0) ? 1 : 0);
    end

    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
